trace_uart_tx: RTL and testbench

Commit-trace transmitter for the single-cycle MIPS core. Each cycle the core retires an instruction, it presents that instruction's `pc` and `inst` with `trace_valid`. This block queues those records and serializes them as 8N1 UART bytes on `tx`, so an external host can reconstruct the execution trace. It sits beside `sccomp_dataflow` at the top level and only observes the core; it never stalls it.

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_fifo.sv | 60 ++++++
 rtl/trace_uart_tx.sv | 143 ++++++++++++++
 tb/tb_trace_uart_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and record-format constants for the commit-trace UART transmitter.
// TRACE_SYNC_EN prefixes each record with SYNC_BYTE, making records 9 bytes long.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

`ifdef TRACE_SYNC_EN
    localparam int RECORD_BYTES = 9;
    localparam int BYTE_IDX_W   = 4;
`else
    localparam int RECORD_BYTES = 8;
    localparam int BYTE_IDX_W   = 3;
`endif

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/trace_fifo.sv
// Record queue: 64-bit synchronous FIFO, write visible to the reader one edge later.
// Pushes while full are silently dropped; full is judged on the registered count only.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap for free because DEPTH is a power of two.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
        pop_dat = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Commit-trace serializer: queues {pc,inst} records and sends them as 8N1 bytes, big-endian.
// tx lags the FSM state by one register; never stalls the core, drops on full (TRACE_SYNC_EN adds 0xA5 sync byte).
module trace_uart_tx #(
    parameter int CLK_DIV = 100,
    parameter int DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_valid,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        tx,
    output logic        busy,
    output logic        trace_overflow
);

    import trace_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BYTE_IDX_W-1:0] BYTE_LAST = BYTE_IDX_W'(RECORD_BYTES - 1);

    tx_state_e             state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [63:0]           shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  ovf_q, ovf_d;

    logic                  fifo_pop;
    logic [63:0]           fifo_dat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  bit_end;
    logic                  shift_en;
    logic [7:0]            cur_byte;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (trace_valid),
        .push_dat ({pc, inst}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
`ifdef TRACE_SYNC_EN
        // Byte 0 is the sync byte; the record itself only starts moving after it.
        cur_byte = (byte_idx_q == '0) ? SYNC_BYTE : shreg_q[63:56];
        shift_en = (byte_idx_q != '0);
`else
        cur_byte = shreg_q[63:56];
        shift_en = 1'b1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        fifo_pop   = 1'b0;
        tx_d       = 1'b1;
        bit_end    = (div_cnt_q == DIV_LAST);
        ovf_d      = ovf_q | (trace_valid & fifo_full);

        if (state_q != IDLE) begin
            div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_d    = fifo_dat;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    div_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx_d = cur_byte[bit_idx_q];
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q == BYTE_LAST) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        if (shift_en) shreg_d = {shreg_q[55:0], 8'h00};
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx             = tx_q;
    assign trace_overflow = ovf_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench for trace_uart_tx: a UART monitor decodes tx and checks bytes against a scoreboard queue.
module tb_trace_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
`ifdef TRACE_SYNC_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int REC_CYC = NB * 10 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic        tx;
    logic        busy;
    logic        trace_overflow;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    trace_uart_tx #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .trace_valid    (trace_valid),
        .pc             (pc),
        .inst           (inst),
        .tx             (tx),
        .busy           (busy),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] i);
        logic [63:0] r;
        r = {p, i};
`ifdef TRACE_SYNC_EN
        exp_q.push_back(8'hA5);
`endif
        for (int k = 0; k < 8; k++) exp_q.push_back(r[63-8*k -: 8]);
    endtask

    task automatic check_gaps(input int n);
        check("start_count", 64'(start_q.size()), 64'(n));
        for (int i = 0; i + 1 < start_q.size(); i++)
            check("start_gap", 64'(start_q[i+1] - start_q[i]),
                  64'(((i + 1) % NB == 0) ? 10 * CLK_DIV + 1 : 10 * CLK_DIV));
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy !== 1'b0; i++) @(negedge clk);
        check("idle_reached", 64'(busy), 64'(0));
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // UART monitor: decodes every frame on tx, abandoning a frame that reset cuts short.
    initial begin : monitor
        logic       prev;
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        logic [7:0] exp_b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && tx === 1'b0) begin
                start_q.push_back(cyc);
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    for (int m = 0; m < CLK_DIV; m++) begin
                        if (j != 0 || m != 0) @(negedge clk);
                        if (reset !== 1'b0) aborted = 1'b1;
                        if (m == 0) bits[j] = tx;
                        else if (tx !== bits[j]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    check("bit_width", 64'(stable), 64'(1));
                    check("stop_bit", 64'(bits[9]), 64'(1));
                    check("byte_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        check("byte_value", 64'(bits[8:1]), 64'(exp_b));
                    end
                end
                prev = tx;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : stimulus
        int n0;
        int bad;
        int sz;

        // Reset, then 50 idle cycles.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", 64'(tx), 64'(1));
            check("idle_busy", 64'(busy), 64'(0));
            check("idle_ovf", 64'(trace_overflow), 64'(0));
        end

        // Single record: latency, byte contents, total occupancy.
        start_q.delete();
        trace_valid = 1'b1;
        pc          = 32'h0040_0000;
        inst        = 32'h3C01_1001;
        push_exp(pc, inst);
        @(negedge clk);
        trace_valid = 1'b0;
        n0 = cyc;
        check("lat_tx_n0", 64'(tx), 64'(1));
        @(negedge clk);
        check("lat_tx_n1", 64'(tx), 64'(1));
        @(negedge clk);
        check("lat_tx_n2", 64'(tx), 64'(0));
        for (int i = 0; i < 2000 && busy !== 1'b0; i++) @(negedge clk);
        check("busy_duration", 64'(cyc - n0), 64'(REC_CYC));
        wait_idle(10);
        check_gaps(NB);
        check("first_start", 64'(start_q[0] - n0), 64'(2));

        // Overflow: six back-to-back pushes into a depth-4 FIFO.
        start_q.delete();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) check("ovf_clear", 64'(trace_overflow), 64'(0));
            trace_valid = 1'b1;
            pc          = 32'h0040_0000 + 32'(4 * i);
            inst        = 32'h2400_0000 + 32'(i);
            if (i < 5) push_exp(pc, inst);
            @(negedge clk);
        end
        trace_valid = 1'b0;
        check("ovf_set", 64'(trace_overflow), 64'(1));
        wait_idle(6 * REC_CYC);
        check("ovf_sticky", 64'(trace_overflow), 64'(1));
        check_gaps(5 * NB);

        // Reset during data bit 3 of byte 2 with two records queued.
        start_q.delete();
        for (int i = 0; i < 3; i++) begin
            trace_valid = 1'b1;
            pc          = 32'h1234_5678 + 32'(i);
            inst        = 32'h8765_4321 + 32'(i);
            if (i == 0) begin
                push_exp(pc, inst);
                while (exp_q.size() > 2) void'(exp_q.pop_back());
            end
            @(negedge clk);
            if (i == 0) n0 = cyc;
        end
        trace_valid = 1'b0;
        for (int i = 0; i < 500 && cyc < n0 + 98; i++) @(negedge clk);
        check("mid_bit3_cycle", 64'(cyc - n0), 64'(98));
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx", 64'(tx), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ovf", 64'(trace_overflow), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        sz = start_q.size();
        check("rst_starts_before", 64'(sz), 64'(3));
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("rst_quiet", 64'(bad), 64'(0));
        check("rst_no_new_starts", 64'(start_q.size()), 64'(sz));
        check("rst_scoreboard", 64'(exp_q.size()), 64'(0));

        // Push on the very edge the FSM pops the queued record from IDLE.
        start_q.delete();
        trace_valid = 1'b1;
        pc          = 32'h0040_0100;
        inst        = 32'h0000_0001;
        push_exp(pc, inst);
        @(negedge clk);
        n0   = cyc;
        pc   = 32'h0040_0104;
        inst = 32'h0000_0002;
        push_exp(pc, inst);
        @(negedge clk);
        trace_valid = 1'b0;
        for (int i = 0; i < 2000 && cyc < n0 + REC_CYC; i++) @(negedge clk);
        trace_valid = 1'b1;
        pc          = 32'h0040_0108;
        inst        = 32'h0000_0003;
        push_exp(pc, inst);
        @(negedge clk);
        trace_valid = 1'b0;
        check("pp_count", 64'(dut.u_fifo.count_q), 64'(1));
        check("pp_ovf", 64'(trace_overflow), 64'(0));
        check("pp_busy", 64'(busy), 64'(1));
        wait_idle(4 * REC_CYC);
        check_gaps(3 * NB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
